// File: rtl/led7seg_595_scanner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : led7seg_pkg                                            |
// | Description : Shared types, defaults and helpers for the 74HC595     |
// |               7-segment scan driver and the timer top.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package led7seg_pkg;

   localparam int DEF_DIG_NUM   = 8;
   localparam int DEF_SEG_NUM   = 8;
   localparam int DEF_DIV_WIDTH = 8;

   // Bit-phase sequencer states; explicit encoding keeps netlists stable.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SHIFT_LO = 3'd1,
      ST_SHIFT_HI = 3'd2,
      ST_LATCH_HI = 3'd3,
      ST_LATCH_LO = 3'd4
   } state_t;

   // One shifted word carries the segment byte followed by the digit select.
   function automatic int cha_width(input int seg_num, input int dig_num);
      return seg_num + dig_num;
   endfunction

endpackage
`default_nettype wire

// File: rtl/led7seg_595_scanner_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : led7seg_595_scanner_if                                 |
// | Description : Frame hand-off from the timer datapath to the scanner. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface led7seg_595_scanner_if
   import led7seg_pkg::*;
#(
   parameter int DIG_NUM = DEF_DIG_NUM,
   parameter int SEG_NUM = DEF_SEG_NUM
) ();

   logic [DIG_NUM*SEG_NUM-1:0] dat;
   logic                       vld;

   modport master (output dat, output vld);
   modport slave  (input  dat, input  vld);

endinterface
`default_nettype wire

// File: rtl/led7seg_595_scanner_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : led7seg_tick_gen                                       |
// | Description : Free-running prescaler; tick once per 2^DIV_WIDTH clk. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module led7seg_tick_gen
   import led7seg_pkg::*;
#(
   parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   logic [DIV_WIDTH-1:0] cnt_q;

   // Prescaler counter, wraps naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = &cnt_q;

endmodule
`default_nettype wire

// File: rtl/led7seg_595_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : led7seg_595_scanner                                    |
// | Description : Multiplexes a packed segment frame onto the serial     |
// |               sclk/rclk/dio chain of an 8-digit 74HC595 display.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module led7seg_595_scanner
   import led7seg_pkg::*;
#(
   parameter int DIG_NUM   = DEF_DIG_NUM,
   parameter int SEG_NUM   = DEF_SEG_NUM,
   parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   led7seg_595_scanner_if.slave        fin,
   output logic                        sclk,
   output logic                        rclk,
   output logic                        dio,
   output logic                        frm
);

   localparam int CHA_WIDTH = cha_width(SEG_NUM, DIG_NUM);
   localparam int DIG_W     = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;
   localparam int CNT_W     = $clog2(CHA_WIDTH + 1);

   localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(CHA_WIDTH - 1);
   localparam logic [DIG_W-1:0] C_LAST_DIG = DIG_W'(DIG_NUM - 1);

   logic                         w_tick;
   state_t                       state_q, state_d;
   logic [DIG_NUM*SEG_NUM-1:0]   frame_q;
   logic                         have_data_q;
   logic [DIG_W-1:0]             dig_q, dig_d;
   logic [CHA_WIDTH-1:0]         shreg_q, shreg_d;
   logic [CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
   logic                         sclk_q, rclk_q, frm_q, frm_d;
   logic [DIG_W-1:0]             w_dig_next, w_load_dig;
   logic [SEG_NUM-1:0]           w_seg;
   logic [DIG_NUM-1:0]           w_onehot;

   led7seg_tick_gen #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   // Frame buffer and first-data flag; only word loads read the buffer,
   // so a mid-digit update never disturbs the word in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_q     <= '0;
         have_data_q <= 1'b0;
      end else begin
         if (fin.vld) begin
            frame_q <= fin.dat;
         end
         have_data_q <= have_data_q | fin.vld;
      end
   end

   // Select the word for the digit about to be loaded: 0 from IDLE,
   // otherwise the successor of the digit just latched.
   always_comb begin
      w_dig_next = (dig_q == C_LAST_DIG) ? '0 : dig_q + 1'b1;
      w_load_dig = (state_q == ST_IDLE) ? '0 : w_dig_next;
      w_seg      = '0;
      w_onehot   = '0;
      for (int i = 0; i < DIG_NUM; i++) begin
         if (w_load_dig == DIG_W'(i)) begin
            w_seg       = frame_q[i*SEG_NUM +: SEG_NUM];
            w_onehot[i] = 1'b1;
         end
      end
   end

   // Next-state logic; every transition is qualified by the bit-phase tick.
   always_comb begin
      state_d   = state_q;
      dig_d     = dig_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      frm_d     = 1'b0;
      if (w_tick) begin
         case (state_q)
            ST_IDLE: begin
               if (have_data_q) begin
                  state_d   = ST_SHIFT_LO;
                  dig_d     = '0;
                  shreg_d   = {w_seg, w_onehot};
                  bit_cnt_d = '0;
               end
            end
            ST_SHIFT_LO: begin
               state_d = ST_SHIFT_HI;
            end
            ST_SHIFT_HI: begin
               shreg_d   = {shreg_q[CHA_WIDTH-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 1'b1;
               state_d   = (bit_cnt_q < C_LAST_BIT) ? ST_SHIFT_LO : ST_LATCH_HI;
            end
            ST_LATCH_HI: begin
               state_d = ST_LATCH_LO;
            end
            ST_LATCH_LO: begin
               state_d   = ST_SHIFT_LO;
               dig_d     = w_dig_next;
               shreg_d   = {w_seg, w_onehot};
               bit_cnt_d = '0;
               frm_d     = (dig_q == C_LAST_DIG);
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State register plus registered output decodes, so the pins never
   // see a combinational path from the inputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         dig_q     <= '0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         sclk_q    <= 1'b0;
         rclk_q    <= 1'b0;
         frm_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         dig_q     <= dig_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         sclk_q    <= (state_d == ST_SHIFT_HI);
         rclk_q    <= (state_d == ST_LATCH_HI);
         frm_q     <= frm_d;
      end
   end

   assign sclk = sclk_q;
   assign rclk = rclk_q;
   assign dio  = shreg_q[CHA_WIDTH-1];
   assign frm  = frm_q;

endmodule
`default_nettype wire

// File: tb/tb_led7seg_595_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_led7seg_595_scanner                                 |
// | Description : Directed self-checking bench for the 595 scan driver.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_led7seg_595_scanner;
   import led7seg_pkg::*;

   localparam logic [63:0] C_PAT  = 64'h0123456789ABCDEF;
   localparam logic [63:0] C_ONES = 64'hFFFFFFFFFFFFFFFF;

   logic clk;
   logic rst;
   logic sclk, rclk, dio, frm;

   led7seg_595_scanner_if #(.DIG_NUM(8), .SEG_NUM(8)) fin ();

   led7seg_595_scanner #(
      .DIG_NUM   (8),
      .SEG_NUM   (8),
      .DIV_WIDTH (2)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .fin  (fin),
      .sclk (sclk),
      .rclk (rclk),
      .dio  (dio),
      .frm  (frm)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Monitor state, sampled on the falling edge away from the active edge.
   logic [15:0] words[$];
   int          nbits[$];
   int          latch_t[$];
   logic [15:0] bitbuf;
   int          bitcnt, hi_len, lo_len, rc_len;
   int          frm_cnt, frm_t, first_rise, idle_act;
   bit          idle_watch;
   logic        p_sclk, p_rclk, p_dio, p_frm;

   always @(negedge clk) begin
      if (!rst) begin
         bitcnt = 0; bitbuf = '0; hi_len = 0; lo_len = 0; rc_len = 0;
         p_sclk = 1'b0; p_rclk = 1'b0; p_dio = 1'b0; p_frm = 1'b0;
      end else begin
         if (idle_watch && (sclk || rclk || dio || frm)) idle_act++;
         if (dio !== p_dio) check("dio_chg_sclk_low", sclk, 0);
         if (sclk && !p_sclk) begin
            if (bitcnt > 0) check("sclk_low_len", lo_len, 4);
            if (first_rise < 0) first_rise = cyc;
            bitbuf = {bitbuf[14:0], dio};
            bitcnt++;
            hi_len = 1;
         end else if (sclk) begin
            hi_len++;
         end
         if (!sclk && p_sclk) begin
            check("sclk_high_len", hi_len, 4);
            lo_len = 1;
         end else if (!sclk) begin
            lo_len++;
         end
         if (rclk && !p_rclk) begin
            words.push_back(bitbuf);
            nbits.push_back(bitcnt);
            latch_t.push_back(cyc);
            bitcnt = 0;
            rc_len = 1;
         end else if (rclk) begin
            rc_len++;
         end
         if (!rclk && p_rclk) check("rclk_len", rc_len, 4);
         if (frm) begin
            check("frm_one_clk", p_frm, 0);
            frm_cnt++;
            frm_t = cyc;
         end
         p_sclk = sclk; p_rclk = rclk; p_dio = dio; p_frm = frm;
      end
   end

   task automatic clear_mon();
      words.delete(); nbits.delete(); latch_t.delete();
      frm_cnt = 0; frm_t = -1; first_rise = -1; idle_act = 0;
   endtask

   task automatic wait_words(input int n, input int budget, input string tag);
      int k = 0;
      while (words.size() < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      check(tag, (words.size() >= n), 1);
   endtask

   task automatic send_frame(input logic [63:0] d);
      @(negedge clk);
      fin.dat = d;
      fin.vld = 1'b1;
      @(negedge clk);
      fin.vld = 1'b0;
   endtask

   logic [15:0] exp_w [8] = '{16'hEF01, 16'hCD02, 16'hAB04, 16'h8908,
                              16'h6710, 16'h4520, 16'h2340, 16'h0180};

   initial begin
      int vld_cyc, k;
      rst = 1'b0;
      fin.dat = '0;
      fin.vld = 1'b0;
      idle_watch = 1'b0;
      clear_mon();

      // Reset then long idle: nothing may toggle without a frame.
      repeat (10) @(negedge clk);
      check("reset_outputs", {sclk, rclk, dio, frm}, 4'b0000);
      rst = 1'b1;
      idle_watch = 1'b1;
      repeat (1000) @(negedge clk);
      idle_watch = 1'b0;
      check("idle_activity", idle_act, 0);
      check("idle_no_latch", words.size(), 0);

      // First full frame with startup latency, word contents and periods.
      clear_mon();
      @(negedge clk);
      fin.dat = C_PAT;
      fin.vld = 1'b1;
      vld_cyc = cyc + 1;
      @(negedge clk);
      fin.vld = 1'b0;
      wait_words(9, 1500, "frame_timeout");
      check("start_latency_ok", (first_rise - vld_cyc >= 1) && (first_rise - vld_cyc <= 9), 1);
      if (words.size() >= 9) begin
         for (int i = 0; i < 8; i++) begin
            check($sformatf("word%0d", i), words[i], exp_w[i]);
            check($sformatf("bits%0d", i), nbits[i], 16);
         end
         check("wrap_word", words[8], 16'hEF01);
         check("digit_period", latch_t[1] - latch_t[0], 136);
         check("frame_period", latch_t[8] - latch_t[0], 1088);
         check("frm_count", frm_cnt, 1);
         check("frm_after_latch7", frm_t - latch_t[7], 8);
      end

      // Mid-digit update: digit 2 keeps old data, digit 3 takes the new.
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      clear_mon();
      rst = 1'b1;
      send_frame(C_PAT);
      k = 0;
      while (!(words.size() == 2 && bitcnt == 5) && k < 800) begin
         @(posedge clk);
         k++;
      end
      check("mid_digit_found", (words.size() == 2 && bitcnt == 5), 1);
      send_frame(C_ONES);
      wait_words(4, 600, "update_timeout");
      if (words.size() >= 4) begin
         check("torn_digit2", words[2], 16'hAB04);
         check("new_digit3", words[3], 16'hFF08);
      end

      // Asynchronous reset between edges while sclk is high.
      k = 0;
      do begin
         @(posedge clk);
         #2;
         k++;
      end while (sclk !== 1'b1 && k < 200);
      check("sclk_high_found", sclk, 1);
      rst = 1'b0;
      #1;
      check("async_rst_outputs", {sclk, rclk, dio, frm}, 4'b0000);
      repeat (3) @(negedge clk);
      clear_mon();
      rst = 1'b1;
      idle_watch = 1'b1;
      repeat (200) @(negedge clk);
      idle_watch = 1'b0;
      check("post_rst_idle", idle_act, 0);
      check("post_rst_no_latch", words.size(), 0);
      send_frame(C_PAT);
      wait_words(2, 400, "restart_timeout");
      if (words.size() >= 2) begin
         check("restart_digit0", words[0], 16'hEF01);
         check("restart_digit1", words[1], 16'hCD02);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
